// File: rtl/mac_seq_pkg.sv
// Shared types and timing constants for the dot-product sequencer.
// The MAC issue spacing follows from the mac_unit pipeline depth.
package mac_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    ISSUE   = 3'd2,
    WAIT1   = 3'd3,
    WAIT2   = 3'd4,
    CAPTURE = 3'd5,
    RESULT  = 3'd6
  } state_e;

  localparam int MAC_LATENCY    = 2;
  localparam int ISSUE_INTERVAL = MAC_LATENCY + 1;

endpackage

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: bias + sum(A[i]*B[i]) on a 2-stage mac_unit fed from
// two synchronous-read operand memories; the result leaves over valid/ready.
module mac_dot_seq
  import mac_seq_pkg::*;
#(
  parameter int DATA_A_WIDTH = 8,
  parameter int DATA_B_WIDTH = 8,
  parameter int ACCUM_WIDTH  = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int LEN_WIDTH    = 11
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [LEN_WIDTH-1:0]    len,
  input  logic [ADDR_WIDTH-1:0]   base_a,
  input  logic [ADDR_WIDTH-1:0]   base_b,
  input  logic [ACCUM_WIDTH-1:0]  bias,
  output logic                    busy,
  output logic                    a_rd_en,
  output logic [ADDR_WIDTH-1:0]   a_rd_addr,
  input  logic [DATA_A_WIDTH-1:0] a_rd_data,
  output logic                    b_rd_en,
  output logic [ADDR_WIDTH-1:0]   b_rd_addr,
  input  logic [DATA_B_WIDTH-1:0] b_rd_data,
  output logic                    mac_en,
  output logic [DATA_A_WIDTH-1:0] mac_data_a,
  output logic [DATA_B_WIDTH-1:0] mac_data_b,
  output logic [ACCUM_WIDTH-1:0]  mac_accum_in,
  input  logic [ACCUM_WIDTH-1:0]  mac_accum_out,
  output logic                    res_valid,
  output logic [ACCUM_WIDTH-1:0]  res_data,
  input  logic                    res_ready,
  output state_e                  dbg_state
);

  state_e                  state_q, state_d;
  logic [LEN_WIDTH-1:0]    idx_q, idx_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [ADDR_WIDTH-1:0]   base_a_q, base_a_d;
  logic [ADDR_WIDTH-1:0]   base_b_q, base_b_d;
  logic [ACCUM_WIDTH-1:0]  bias_q, bias_d;
  logic                    busy_q, busy_d;
  logic                    a_rd_en_q, a_rd_en_d;
  logic                    b_rd_en_q, b_rd_en_d;
  logic [ADDR_WIDTH-1:0]   a_rd_addr_q, a_rd_addr_d;
  logic [ADDR_WIDTH-1:0]   b_rd_addr_q, b_rd_addr_d;
  logic                    mac_en_q, mac_en_d;
  logic                    res_valid_q, res_valid_d;
  logic [ACCUM_WIDTH-1:0]  res_data_q, res_data_d;

  logic [LEN_WIDTH-1:0]    next_idx;
  logic [ADDR_WIDTH-1:0]   next_off;
  logic                    more_elems;

  assign next_idx   = idx_q + LEN_WIDTH'(1);
  assign next_off   = next_idx[ADDR_WIDTH-1:0];
  assign more_elems = (next_idx < len_q);

  // Operand data goes straight from the memories into the MAC; only element 0
  // starts from the bias, later elements chain the MAC's own output.
  assign mac_data_a   = a_rd_data;
  assign mac_data_b   = b_rd_data;
  assign mac_accum_in = (idx_q == '0) ? bias_q : mac_accum_out;

  // Result handshake: res_valid rises with res_data already stable; both hold
  // unchanged until a cycle where res_valid && res_ready, which is the transfer.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    base_a_d    = base_a_q;
    base_b_d    = base_b_q;
    bias_d      = bias_q;
    busy_d      = busy_q;
    a_rd_en_d   = 1'b0;
    b_rd_en_d   = 1'b0;
    a_rd_addr_d = a_rd_addr_q;
    b_rd_addr_d = b_rd_addr_q;
    mac_en_d    = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          len_d    = len;
          base_a_d = base_a;
          base_b_d = base_b;
          bias_d   = bias;
          idx_d    = '0;
          busy_d   = 1'b1;
          if (len == '0) begin
            res_data_d  = bias;
            res_valid_d = 1'b1;
            state_d     = RESULT;
          end else begin
            a_rd_en_d   = 1'b1;
            b_rd_en_d   = 1'b1;
            a_rd_addr_d = base_a;
            b_rd_addr_d = base_b;
            state_d     = FETCH;
          end
        end
      end
      FETCH: begin
        mac_en_d = 1'b1;
        state_d  = ISSUE;
      end
      ISSUE: begin
        state_d = WAIT1;
      end
      WAIT1: begin
        // Strobes are registered, so the overlapped read for the next element
        // is launched here to be visible throughout WAIT2.
        if (more_elems) begin
          a_rd_en_d   = 1'b1;
          b_rd_en_d   = 1'b1;
          a_rd_addr_d = base_a_q + next_off;
          b_rd_addr_d = base_b_q + next_off;
        end
        state_d = WAIT2;
      end
      WAIT2: begin
        if (more_elems) begin
          idx_d    = next_idx;
          mac_en_d = 1'b1;
          state_d  = ISSUE;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        res_data_d  = mac_accum_out;
        res_valid_d = 1'b1;
        state_d     = RESULT;
      end
      RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Any MAC result still in flight is simply never picked up.
    if (abort) begin
      state_d     = IDLE;
      idx_d       = '0;
      busy_d      = 1'b0;
      a_rd_en_d   = 1'b0;
      b_rd_en_d   = 1'b0;
      mac_en_d    = 1'b0;
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      base_a_q    <= '0;
      base_b_q    <= '0;
      bias_q      <= '0;
      busy_q      <= 1'b0;
      a_rd_en_q   <= 1'b0;
      b_rd_en_q   <= 1'b0;
      a_rd_addr_q <= '0;
      b_rd_addr_q <= '0;
      mac_en_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      base_a_q    <= base_a_d;
      base_b_q    <= base_b_d;
      bias_q      <= bias_d;
      busy_q      <= busy_d;
      a_rd_en_q   <= a_rd_en_d;
      b_rd_en_q   <= b_rd_en_d;
      a_rd_addr_q <= a_rd_addr_d;
      b_rd_addr_q <= b_rd_addr_d;
      mac_en_q    <= mac_en_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign busy      = busy_q;
  assign a_rd_en   = a_rd_en_q;
  assign b_rd_en   = b_rd_en_q;
  assign a_rd_addr = a_rd_addr_q;
  assign b_rd_addr = b_rd_addr_q;
  assign mac_en    = mac_en_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mac_dot_seq.sv
// Directed bench for mac_dot_seq: behavioural 2-stage MAC and 1-cycle SRAMs,
// one task per scenario with hand-computed expected results.
module tb_mac_dot_seq;
  import mac_seq_pkg::*;

  localparam int AW  = 8;
  localparam int BW  = 8;
  localparam int CW  = 32;
  localparam int ADW = 10;
  localparam int LW  = 11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0, start16 = 1'b0, abort = 1'b0, res_ready = 1'b0;
  logic [LW-1:0] len = '0;
  logic [ADW-1:0] base_a = '0, base_b = '0;
  logic [CW-1:0] bias = '0;
  logic [15:0]   bias16 = '0;

  logic          busy, a_rd_en, b_rd_en, mac_en, res_valid;
  logic [ADW-1:0] a_rd_addr, b_rd_addr;
  logic [AW-1:0] a_rd_data, mac_data_a;
  logic [BW-1:0] b_rd_data, mac_data_b;
  logic [CW-1:0] mac_accum_in, mac_accum_out, res_data;
  state_e        dbg_state;

  logic          busy16, a_rd_en16, b_rd_en16, mac_en16, res_valid16;
  logic [ADW-1:0] a_rd_addr16, b_rd_addr16;
  logic [AW-1:0] a_rd_data16, mac_data_a16;
  logic [BW-1:0] b_rd_data16, mac_data_b16;
  logic [15:0]   mac_accum_in16, mac_accum_out16, res_data16;
  state_e        dbg_state16;

  mac_dot_seq #(.DATA_A_WIDTH(AW), .DATA_B_WIDTH(BW), .ACCUM_WIDTH(CW),
                .ADDR_WIDTH(ADW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .len(len),
    .base_a(base_a), .base_b(base_b), .bias(bias), .busy(busy),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
    .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
    .mac_en(mac_en), .mac_data_a(mac_data_a), .mac_data_b(mac_data_b),
    .mac_accum_in(mac_accum_in), .mac_accum_out(mac_accum_out),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .dbg_state(dbg_state)
  );

  mac_dot_seq #(.DATA_A_WIDTH(AW), .DATA_B_WIDTH(BW), .ACCUM_WIDTH(16),
                .ADDR_WIDTH(ADW), .LEN_WIDTH(LW)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .abort(abort), .len(len),
    .base_a(base_a), .base_b(base_b), .bias(bias16), .busy(busy16),
    .a_rd_en(a_rd_en16), .a_rd_addr(a_rd_addr16), .a_rd_data(a_rd_data16),
    .b_rd_en(b_rd_en16), .b_rd_addr(b_rd_addr16), .b_rd_data(b_rd_data16),
    .mac_en(mac_en16), .mac_data_a(mac_data_a16), .mac_data_b(mac_data_b16),
    .mac_accum_in(mac_accum_in16), .mac_accum_out(mac_accum_out16),
    .res_valid(res_valid16), .res_data(res_data16), .res_ready(res_ready),
    .dbg_state(dbg_state16)
  );

  // ---------------- behavioural memories and MACs ----------------
  logic [7:0] mem_a [0:1023];
  logic [7:0] mem_b [0:1023];

  always @(posedge clk) begin
    if (a_rd_en)   a_rd_data   <= mem_a[a_rd_addr];
    if (b_rd_en)   b_rd_data   <= mem_b[b_rd_addr];
    if (a_rd_en16) a_rd_data16 <= mem_a[a_rd_addr16];
    if (b_rd_en16) b_rd_data16 <= mem_b[b_rd_addr16];
  end

  logic signed [15:0] m_prod, m16_prod;
  logic [31:0] m_acc1, m_sum;
  logic [15:0] m16_acc1, m16_sum;
  logic m_v1, m_v2, m16_v1, m16_v2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prod <= '0; m_acc1 <= '0; m_sum <= '0; mac_accum_out <= '0;
      m_v1 <= 1'b0; m_v2 <= 1'b0;
      m16_prod <= '0; m16_acc1 <= '0; m16_sum <= '0; mac_accum_out16 <= '0;
      m16_v1 <= 1'b0; m16_v2 <= 1'b0;
    end else begin
      m_v1 <= mac_en;
      m_v2 <= m_v1;
      if (mac_en) begin
        m_prod <= $signed(mac_data_a) * $signed(mac_data_b);
        m_acc1 <= mac_accum_in;
      end
      if (m_v1) m_sum <= m_acc1 + {{16{m_prod[15]}}, m_prod};
      if (m_v2) mac_accum_out <= m_sum;
      m16_v1 <= mac_en16;
      m16_v2 <= m16_v1;
      if (mac_en16) begin
        m16_prod <= $signed(mac_data_a16) * $signed(mac_data_b16);
        m16_acc1 <= mac_accum_in16;
      end
      if (m16_v1) m16_sum <= m16_acc1 + m16_prod;
      if (m16_v2) mac_accum_out16 <= m16_sum;
    end
  end

  // ---------------- monitors ----------------
  int cyc = 0;
  int issue_q[$];
  logic [ADW-1:0] addr_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mac_en)  issue_q.push_back(cyc + 1);
    if (a_rd_en) addr_q.push_back(a_rd_addr);
  end

  int errors = 0;
  int checks = 0;
  logic [ADW-1:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int n, input int ba, input int bb, input logic [CW-1:0] b,
                        output int s);
    len = LW'(n); base_a = ADW'(ba); base_b = ADW'(bb); bias = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    s = cyc;
  endtask

  task automatic wait_valid(input int maxc, output int seen);
    seen = -1;
    for (int i = 0; i < maxc; i++) begin
      if (res_valid) begin
        seen = cyc;
        break;
      end
      tick();
    end
  endtask

  task automatic accept();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    tick(); tick();
    checks++;
    if ({busy, a_rd_en, b_rd_en, mac_en, res_valid} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes: got %b want 00000", {busy, a_rd_en, b_rd_en, mac_en, res_valid});
    end
    checks++;
    if (res_data !== 32'd0 || a_rd_addr !== 10'd0 || b_rd_addr !== 10'd0) begin
      errors++; $display("FAIL reset_data: res_data=%0h a=%0d b=%0d want 0", res_data, a_rd_addr, b_rd_addr);
    end
    checks++;
    if (dbg_state !== IDLE) begin
      errors++; $display("FAIL reset_state: got %0d want IDLE", dbg_state);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int s, seen, n0, bad;
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = 8'(i + 1);
      mem_b[100 + i] = 8'(i + 5);
    end
    n0 = issue_q.size();
    launch(4, 0, 100, 32'd10, s);
    wait_valid(40, seen);
    checks++;
    if (seen != s + 14) begin
      errors++; $display("FAIL basic_latency: valid after edge %0d want %0d", seen, s + 14);
    end
    checks++;
    if (res_data !== 32'd80) begin
      errors++; $display("FAIL basic_result: got %0d want 80", $signed(res_data));
    end
    checks++;
    if (issue_q.size() - n0 != 4) begin
      errors++; $display("FAIL basic_issue_count: got %0d want 4", issue_q.size() - n0);
    end else begin
      bad = 0;
      for (int i = 0; i < 4; i++)
        if (issue_q[n0 + i] != s + 2 + ISSUE_INTERVAL * i) bad++;
      if (bad != 0) begin
        errors++; $display("FAIL basic_issue_spacing: %0d issues off, first at %0d want %0d", bad, issue_q[n0], s + 2);
      end
    end
    accept();
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++; $display("FAIL basic_accept: busy=%b valid=%b want 0 0", busy, res_valid);
    end
  endtask

  task automatic test_len0();
    int s, n0, r0;
    n0 = issue_q.size();
    r0 = addr_q.size();
    launch(0, 5, 5, 32'hFFFF_FFF9, s);
    checks++;
    if (res_valid !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL len0_valid: valid=%b busy=%b want 1 1", res_valid, busy);
    end
    checks++;
    if (res_data !== 32'hFFFF_FFF9) begin
      errors++; $display("FAIL len0_result: got %0d want -7", $signed(res_data));
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (issue_q.size() != n0 || addr_q.size() != r0 || b_rd_en !== 1'b0) begin
      errors++; $display("FAIL len0_no_work: issues=%0d reads=%0d want 0 0", issue_q.size() - n0, addr_q.size() - r0);
    end
    accept();
  endtask

  task automatic test_signed();
    int s, seen;
    mem_a[200] = 8'h80; mem_a[201] = 8'h80; mem_a[202] = 8'h7F;
    mem_b[300] = 8'h80; mem_b[301] = 8'h7F; mem_b[302] = 8'hFF;
    launch(3, 200, 300, 32'd0, s);
    wait_valid(40, seen);
    checks++;
    if (res_data !== 32'd1 || seen != s + 11) begin
      errors++; $display("FAIL signed_result: got %0d at %0d want 1 at %0d", $signed(res_data), seen, s + 11);
    end
    accept();
    // 32-bit wrap: 0x7FFFFFFF + 2*1 wraps to 0x80000001
    mem_a[210] = 8'd2; mem_b[310] = 8'd1;
    launch(1, 210, 310, 32'h7FFF_FFFF, s);
    wait_valid(20, seen);
    checks++;
    if (res_data !== 32'h8000_0001) begin
      errors++; $display("FAIL wrap32_result: got %h want 80000001", res_data);
    end
    accept();
  endtask

  task automatic test_wrap16();
    int seen;
    mem_a[400] = 8'd1; mem_b[400] = 8'd1;
    len = LW'(1); base_a = 10'd400; base_b = 10'd400; bias16 = 16'h7FFF;
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    seen = -1;
    for (int i = 0; i < 20; i++) begin
      if (res_valid16) begin seen = cyc; break; end
      tick();
    end
    checks++;
    if (seen < 0 || res_data16 !== 16'h8000) begin
      errors++; $display("FAIL wrap16_result: valid_at=%0d got %0d want -32768", seen, $signed(res_data16));
    end
    accept();
    checks++;
    if (res_valid16 !== 1'b0 || busy16 !== 1'b0) begin
      errors++; $display("FAIL wrap16_accept: valid=%b busy=%b want 0 0", res_valid16, busy16);
    end
  endtask

  task automatic test_backpressure();
    int s, seen, bad, n1;
    mem_a[500] = 8'hFD; mem_a[501] = 8'd4;
    mem_b[500] = 8'd5;  mem_b[501] = 8'd6;
    launch(2, 500, 500, 32'd100, s);
    wait_valid(30, seen);
    checks++;
    if (res_data !== 32'd109) begin
      errors++; $display("FAIL bp_result: got %0d want 109", $signed(res_data));
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        len = LW'(1); base_a = 10'd0; base_b = 10'd0; bias = 32'd5; start = 1'b1;
      end
      tick();
      start = 1'b0;
      if (res_valid !== 1'b1 || res_data !== 32'd109) bad++;
    end
    checks++;
    if (bad != 0 || dbg_state !== RESULT) begin
      errors++; $display("FAIL bp_hold: %0d unstable cycles state=%0d want 0 RESULT", bad, dbg_state);
    end
    n1 = issue_q.size();
    // start coinciding with the accepting cycle must not launch a job
    res_ready = 1'b1; start = 1'b1;
    tick();
    res_ready = 1'b0; start = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_accept: valid=%b busy=%b want 0 0", res_valid, busy);
    end
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (busy !== 1'b0 || issue_q.size() != n1) begin
      errors++; $display("FAIL bp_ignored_start: busy=%b issues=%0d want 0 0", busy, issue_q.size() - n1);
    end
  endtask

  task automatic test_abort();
    int s, seen, n0, bad;
    for (int i = 0; i < 5; i++) begin
      mem_a[600 + i] = 8'(i + 1);
      mem_b[600 + i] = 8'd1;
    end
    n0 = issue_q.size();
    launch(5, 600, 600, 32'd0, s);
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (dbg_state !== WAIT1) begin
      errors++; $display("FAIL abort_position: state=%0d want WAIT1", dbg_state);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || dbg_state !== IDLE) begin
      errors++; $display("FAIL abort_idle: busy=%b state=%0d want 0 IDLE", busy, dbg_state);
    end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if ({mac_en, a_rd_en, b_rd_en, res_valid} !== 4'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0 || issue_q.size() - n0 != 3) begin
      errors++; $display("FAIL abort_quiet: %0d active cycles, issues=%0d want 0 3", bad, issue_q.size() - n0);
    end
    abort = 1'b1; start = 1'b1; len = LW'(2);
    tick();
    abort = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL abort_beats_start: busy=%b want 0", busy);
    end
    mem_a[700] = 8'd3; mem_a[701] = 8'd3;
    mem_b[700] = 8'd2; mem_b[701] = 8'd2;
    launch(2, 700, 700, 32'd0, s);
    wait_valid(30, seen);
    checks++;
    if (seen < 0 || res_data !== 32'd12) begin
      errors++; $display("FAIL abort_restart: got %0d want 12", $signed(res_data));
    end
    accept();
  endtask

  task automatic test_addr_wrap();
    int s, seen, a0, bad;
    mem_a[1022] = 8'd1; mem_a[1023] = 8'd1; mem_a[0] = 8'd1; mem_a[1] = 8'd1;
    for (int i = 0; i < 4; i++) mem_b[800 + i] = 8'(i + 1);
    exp_q.delete();
    exp_q.push_back(10'd1022); exp_q.push_back(10'd1023);
    exp_q.push_back(10'd0);    exp_q.push_back(10'd1);
    a0 = addr_q.size();
    launch(4, 1022, 800, 32'd0, s);
    wait_valid(40, seen);
    checks++;
    if (res_data !== 32'd10) begin
      errors++; $display("FAIL wrap_result: got %0d want 10", $signed(res_data));
    end
    bad = 0;
    if (addr_q.size() - a0 != 4) bad = 99;
    else for (int i = 0; i < 4; i++) if (addr_q[a0 + i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL wrap_addr_seq: %0d wrong, first got %0d want 1022", bad, addr_q[a0]);
    end
    accept();
    launch(4, 1022, 800, 32'd0, s);
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL rst_midjob_busy: got %b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, a_rd_en, b_rd_en, mac_en, res_valid} !== 5'b0 || res_data !== 32'd0 ||
        a_rd_addr !== 10'd0 || b_rd_addr !== 10'd0 || dbg_state !== IDLE) begin
      errors++; $display("FAIL rst_async: strobes=%b res=%0h a=%0d b=%0d want all 0",
                         {busy, a_rd_en, b_rd_en, mac_en, res_valid}, res_data, a_rd_addr, b_rd_addr);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len0();
    test_signed();
    test_wrap16();
    test_backpressure();
    test_abort();
    test_addr_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
